fft_frame_sched: RTL and testbench

FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

---
 rtl/fft_frame_sched.sv | 129 ++++++++++++
 tb/tb_fft_frame_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
`timescale 1ns/1ps
// Frame scheduler: buffers complex samples in a FIFO and releases them to an FFT
// pipeline in N-sample bursts, tracking frames in flight via the returned fft_oen.
module fft_frame_sched #(
  parameter int N            = 64,
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 128,
  parameter int GAP          = 0,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data_r,
  input  logic [WIDTH-1:0]         s_data_i,
  output logic                     fft_en,
  output logic [WIDTH-1:0]         fft_data_r,
  output logic [WIDTH-1:0]         fft_data_i,
  input  logic                     fft_oen,
  output logic                     frame_done,
  output logic [2:0]               inflight,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err,
  input  logic                     err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(N);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [AW:0]        r_level;
  logic               r_rdy;
  state_t             r_state, w_nstate;
  logic [NW-1:0]      r_bcnt, r_ocnt, w_ocnt_nx;
  logic [GW-1:0]      r_gcnt;
  logic [2:0]         r_inflight;
  logic               r_fft_en, r_done, r_err;
  logic [WIDTH-1:0]   r_fft_r, r_fft_i;
  logic               w_push, w_pop, w_issue, w_done, w_drop, w_err, w_dec;

  assign s_ready    = r_rdy && (r_level != (AW+1)'(DEPTH));
  assign w_push     = s_valid && s_ready;
  assign w_issue    = (r_state == S_IDLE) && (r_level >= (AW+1)'(N)) &&
                      (r_inflight < 3'(MAX_INFLIGHT));
  assign level      = r_level;
  assign inflight   = r_inflight;
  assign fft_en     = r_fft_en;
  assign fft_data_r = r_fft_r;
  assign fft_data_i = r_fft_i;
  assign frame_done = r_done;
  assign err        = r_err;

  always_ff @(posedge clock)
    if (w_push) r_mem[r_wptr] <= {s_data_r, s_data_i};

  // Ending a burst through IDLE keeps fft_en continuous when the next frame is
  // already available, since IDLE issues on the very next edge.
  always_comb begin
    w_nstate = r_state;
    w_pop    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_issue) begin w_nstate = S_BURST; w_pop = 1'b1; end
      S_BURST: begin
        w_pop = 1'b1;
        if (r_bcnt == NW'(N-1)) w_nstate = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP:   if (r_gcnt == GW'(GAP-1)) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    w_done    = 1'b0;
    w_drop    = 1'b0;
    w_err     = 1'b0;
    w_ocnt_nx = r_ocnt;
    if (fft_oen) begin
      if (r_inflight == 3'd0 && r_ocnt == '0) w_err = 1'b1;
      else if (r_ocnt == NW'(N-1)) begin w_done = 1'b1; w_ocnt_nx = '0; end
      else w_ocnt_nx = r_ocnt + 1'b1;
    end else if (r_ocnt != '0) begin
      w_err     = 1'b1;
      w_drop    = 1'b1;
      w_ocnt_nx = '0;
    end
  end

  assign w_dec = (w_done || w_drop) && (r_inflight != 3'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy      <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_state    <= S_IDLE;
      r_bcnt     <= '0;
      r_gcnt     <= '0;
      r_ocnt     <= '0;
      r_inflight <= '0;
      r_fft_en   <= 1'b0;
      r_fft_r    <= '0;
      r_fft_i    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rdy   <= 1'b1;
      r_state <= w_nstate;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      // N is a power of two, so the burst counter wraps to 0 on the Nth pop
      if (w_pop) r_bcnt <= r_bcnt + 1'b1;
      r_gcnt <= (r_state == S_GAP && w_nstate == S_GAP) ? r_gcnt + 1'b1 : '0;
      r_fft_en <= w_pop;
      {r_fft_r, r_fft_i} <= w_pop ? r_mem[r_rptr] : '0;
      r_ocnt <= w_ocnt_nx;
      r_done <= w_done;
      if (w_issue && !w_dec)      r_inflight <= r_inflight + 1'b1;
      else if (!w_issue && w_dec) r_inflight <= r_inflight - 1'b1;
      r_err <= w_err || (r_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_fft_frame_sched.sv
`timescale 1ns/1ps
// Directed bench for fft_frame_sched: loopback pipeline model, burst/order monitors,
// FIFO-full stall, inflight limit, gap spacing, reset mid-burst and error handling.
module tb_fft_frame_sched;
  localparam int W = 16, LAT = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, s_valid, s_ready, fft_en, fft_oen, frame_done, err, err_clr;
  logic [W-1:0] s_data_r, s_data_i, fft_data_r, fft_data_i;
  logic [2:0] inflight;
  logic [7:0] level;
  logic g_valid, g_ready, g_en, g_done, g_err;
  logic g_zero = 1'b0;
  logic [W-1:0] g_dr, g_di;
  logic [2:0] g_infl;
  logic [7:0] g_level;
  logic loop_on, oen_man, mon_clr;
  logic [LAT-1:0] en_dly = '0;

  int n_chk = 0, n_err = 0;

  fft_frame_sched #(.N(64), .WIDTH(16), .DEPTH(128), .GAP(0), .MAX_INFLIGHT(2)) u_dut (
    .clock(clk), .reset_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data_r(s_data_r), .s_data_i(s_data_i), .fft_en(fft_en),
    .fft_data_r(fft_data_r), .fft_data_i(fft_data_i), .fft_oen(fft_oen),
    .frame_done(frame_done), .inflight(inflight), .level(level),
    .err(err), .err_clr(err_clr));

  fft_frame_sched #(.N(64), .WIDTH(16), .DEPTH(128), .GAP(3), .MAX_INFLIGHT(2)) u_gap (
    .clock(clk), .reset_n(rst_n), .s_valid(g_valid), .s_ready(g_ready),
    .s_data_r(s_data_r), .s_data_i(s_data_i), .fft_en(g_en),
    .fft_data_r(g_dr), .fft_data_i(g_di), .fft_oen(g_zero),
    .frame_done(g_done), .inflight(g_infl), .level(g_level),
    .err(g_err), .err_clr(g_zero));

  // FFT pipeline model: fft_en returns as fft_oen LAT cycles later
  always @(posedge clk) en_dly <= {en_dly[LAT-2:0], fft_en & loop_on};
  assign fft_oen = loop_on ? en_dly[LAT-1] : oen_man;

  int run, en_cnt, done_cnt, peak;
  int runs[$];
  logic [31:0] got_q[$], exp_q[$];
  always @(negedge clk) begin
    if (mon_clr) begin
      run <= 0; en_cnt <= 0; done_cnt <= 0; peak <= 0;
      runs.delete(); got_q.delete();
    end else begin
      if (fft_en) begin
        run <= run + 1; en_cnt <= en_cnt + 1;
        got_q.push_back({fft_data_r, fft_data_i});
      end else if (run != 0) begin
        runs.push_back(run); run <= 0;
      end
      if (frame_done) done_cnt <= done_cnt + 1;
      if (int'(inflight) > peak) peak <= int'(inflight);
    end
  end

  int g_run, g_low;
  bit g_seen;
  int g_runs[$], g_lows[$];
  always @(negedge clk) begin
    if (mon_clr) begin
      g_run <= 0; g_low <= 0; g_seen <= 1'b0; g_runs.delete(); g_lows.delete();
    end else if (g_en) begin
      if (g_seen && g_low != 0) g_lows.push_back(g_low);
      g_low <= 0; g_run <= g_run + 1; g_seen <= 1'b1;
    end else begin
      if (g_run != 0) g_runs.push_back(g_run);
      g_run <= 0;
      if (g_seen) g_low <= g_low + 1;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
  endtask

  task automatic push_n(input bit gsel, input int n, input int base);
    int acc = 0;
    for (int k = 0; k < n + 1000 && acc < n; k++) begin
      if (gsel) g_valid = 1'b1; else s_valid = 1'b1;
      s_data_r = 16'(base + acc);
      s_data_i = ~16'(base + acc);
      if (gsel ? g_ready : s_ready) begin
        if (!gsel) exp_q.push_back({s_data_r, s_data_i});
        acc++;
      end
      tick();
    end
    s_valid = 1'b0; g_valid = 1'b0;
    chk("push_cnt", acc, n);
  endtask

  function automatic int order_bad();
    int b = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) b++;
    return b;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; g_valid = 1'b0; s_data_r = '0; s_data_i = '0;
    err_clr = 1'b0; oen_man = 1'b0; loop_on = 1'b0; mon_clr = 1'b0;
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_fft_en", fft_en, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    chk("rst_done", frame_done, 0);
    rst_n = 1'b1;
    tick();
    chk("s_ready_after_rst", s_ready, 1);

    // GAP=3 instance: two frames queued back to back
    clr_mon();
    push_n(1'b1, 128, 16'h100);
    for (int k = 0; k < 400 && g_runs.size() < 2; k++) tick();
    chk("gap_runs", g_runs.size(), 2);
    chk("gap_run0", g_runs.size() > 0 ? g_runs[0] : -1, 64);
    chk("gap_run1", g_runs.size() > 1 ? g_runs[1] : -1, 64);
    chk("gap_low", g_lows.size() > 0 ? g_lows[0] : -1, 3);
    chk("gap_inflight", g_infl, 2);

    // Single frame through loopback pipeline
    clr_mon(); exp_q.delete(); loop_on = 1'b1;
    push_n(1'b0, 64, 0);
    for (int k = 0; k < 600 && done_cnt < 1; k++) tick();
    repeat (3) tick();
    chk("t1_runs", runs.size(), 1);
    chk("t1_run_len", runs.size() > 0 ? runs[0] : -1, 64);
    chk("t1_order", order_bad(), 0);
    chk("t1_done", done_cnt, 1);
    chk("t1_peak", peak, 1);
    chk("t1_inflight", inflight, 0);
    chk("t1_err", err, 0);

    // 128 continuous samples: one unbroken 128-cycle run
    clr_mon(); exp_q.delete();
    push_n(1'b0, 128, 16'h200);
    for (int k = 0; k < 800 && done_cnt < 2; k++) tick();
    repeat (3) tick();
    chk("t2_runs", runs.size(), 1);
    chk("t2_run_len", runs.size() > 0 ? runs[0] : -1, 128);
    chk("t2_peak", peak, 2);
    chk("t2_order", order_bad(), 0);
    chk("t2_done", done_cnt, 2);
    chk("t2_inflight", inflight, 0);
    chk("t2_level", level, 0);

    // Output stalled: two frames issued, FIFO fills, third frame held back
    loop_on = 1'b0;
    clr_mon(); exp_q.delete();
    push_n(1'b0, 256, 16'h400);
    chk("t3_level_full", level, 128);
    chk("t3_s_ready", s_ready, 0);
    chk("t3_inflight", inflight, 2);
    chk("t3_en_idle", fft_en, 0);
    s_valid = 1'b1;
    repeat (5) tick();
    s_valid = 1'b0;
    chk("t3_no_push", level, 128);
    chk("t3_no_third", runs.size(), 1);
    oen_man = 1'b1;
    repeat (64) tick();
    oen_man = 1'b0;
    chk("t3_done_pulse", frame_done, 1);
    chk("t3_inflight_dec", inflight, 1);
    tick();
    chk("t3_third_en", fft_en, 1);
    chk("t3_third_infl", inflight, 2);
    chk("t3_pulse_len", frame_done, 0);

    // Reset in cycle 20 of the third burst
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_en", fft_en, 0);
    chk("t4_rst_level", level, 0);
    chk("t4_rst_infl", inflight, 0);
    chk("t4_rst_data", fft_data_r, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh frame needs 64 new pushes
    clr_mon(); exp_q.delete();
    push_n(1'b0, 63, 16'h800);
    repeat (5) tick();
    chk("t4_no_issue_63", en_cnt, 0);
    chk("t4_level_63", level, 63);
    push_n(1'b0, 1, 16'h800 + 63);
    for (int k = 0; k < 100 && runs.size() < 1; k++) tick();
    chk("t4_run_len", runs.size() > 0 ? runs[0] : -1, 64);
    chk("t4_order", order_bad(), 0);
    chk("t4_inflight", inflight, 1);

    // Protocol errors
    oen_man = 1'b1;
    repeat (10) tick();
    oen_man = 1'b0;
    tick();
    chk("t5_drop_err", err, 1);
    chk("t5_drop_infl", inflight, 0);
    chk("t5_no_done", done_cnt, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t5_clr", err, 0);
    err_clr = 1'b1; oen_man = 1'b1; tick(); err_clr = 1'b0; oen_man = 1'b0;
    chk("t5_clr_vs_new", err, 1);
    chk("t5_idle_infl", inflight, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t5_ignored_cycle", err, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
